// File: rtl/mem8_regbank.sv
// Seekable 32-byte register bank behind the Xillybus mem_8 read/write stream pair.
// The read and write streams share one auto-incrementing 5-bit address pointer.
module mem8_regbank #(
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter logic [3:0] LED_RESET = 4'h0
) (
  input  logic       bus_clk,
  input  logic       bus_rst,
  input  logic       user_w_mem_8_wren,
  input  logic [7:0] user_w_mem_8_data,
  output logic       user_w_mem_8_full,
  input  logic       user_w_mem_8_open,
  input  logic       user_r_mem_8_rden,
  output logic [7:0] user_r_mem_8_data,
  output logic       user_r_mem_8_empty,
  output logic       user_r_mem_8_eof,
  input  logic       user_r_mem_8_open,
  input  logic [4:0] user_mem_8_addr,
  input  logic       user_mem_8_addr_update,
  output logic [3:0] led_out,
  output logic       wr_event
);

  localparam logic [4:0] RAM_LAST = 5'd27;
  localparam logic [4:0] LED_ADDR = 5'd28;
  localparam logic [4:0] WCNT_ADDR = 5'd29;
  localparam logic [4:0] RCNT_ADDR = 5'd30;

  logic [7:0] ram [0:27];

  logic [4:0] addr_reg, addr_next;
  logic [3:0] led_reg;
  logic [7:0] wr_cnt_reg, rd_cnt_reg;
  logic [7:0] rd_data_reg;
  logic       wr_event_reg;

  logic       ram_hit;
  logic       ram_we;
  logic       both_closed;
  logic [7:0] rd_byte;

  assign ram_hit     = (addr_reg <= RAM_LAST);
  // A strobe coinciding with reset is dropped, including the RAM write.
  assign ram_we      = user_w_mem_8_wren & ram_hit & ~bus_rst;
  assign both_closed = ~user_w_mem_8_open & ~user_r_mem_8_open;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_reg)
      LED_ADDR:  rd_byte = {4'h0, led_reg};
      WCNT_ADDR: rd_byte = wr_cnt_reg;
      RCNT_ADDR: rd_byte = rd_cnt_reg;
      5'd31:     rd_byte = ID_VALUE;
      default:   rd_byte = ram[addr_reg];
    endcase
  end

  // Seek wins over auto-increment; a combined read+write advances by one.
  always_comb begin
    addr_next = addr_reg;
    if (user_mem_8_addr_update)
      addr_next = user_mem_8_addr;
    else if (user_w_mem_8_wren | user_r_mem_8_rden)
      addr_next = addr_reg + 5'd1;
  end

  always_ff @(posedge bus_clk) begin
    if (ram_we)
      ram[addr_reg] <= user_w_mem_8_data;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      addr_reg     <= 5'd0;
      led_reg      <= LED_RESET;
      wr_cnt_reg   <= 8'd0;
      rd_cnt_reg   <= 8'd0;
      rd_data_reg  <= 8'd0;
      wr_event_reg <= 1'b0;
    end else begin
      addr_reg     <= addr_next;
      wr_event_reg <= user_w_mem_8_wren;
      if (user_w_mem_8_wren && addr_reg == LED_ADDR)
        led_reg <= user_w_mem_8_data[3:0];
      // rd_byte reflects pre-edge state, giving read-before-write semantics.
      if (user_r_mem_8_rden)
        rd_data_reg <= rd_byte;
      if (both_closed) begin
        wr_cnt_reg <= 8'd0;
        rd_cnt_reg <= 8'd0;
      end else begin
        if (user_w_mem_8_wren)
          wr_cnt_reg <= wr_cnt_reg + 8'd1;
        if (user_r_mem_8_rden)
          rd_cnt_reg <= rd_cnt_reg + 8'd1;
      end
    end
  end

  assign user_r_mem_8_data  = rd_data_reg;
  assign led_out            = led_reg;
  assign wr_event           = wr_event_reg;
  assign user_w_mem_8_full  = 1'b0;
  assign user_r_mem_8_empty = 1'b0;
  assign user_r_mem_8_eof   = 1'b0;

endmodule

// File: tb/tb_mem8_regbank.sv
// Randomized scoreboard bench for mem8_regbank against a byte-map reference model.
module tb_mem8_regbank;

  localparam logic [7:0] ID_V  = 8'hA5;
  localparam logic [3:0] LED_R = 4'h9;

  logic       bus_clk = 1'b0;
  logic       bus_rst = 1'b1;
  logic       wren = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       full;
  logic       w_open = 1'b1;
  logic       rden = 1'b0;
  logic [7:0] rdata;
  logic       empty;
  logic       eof;
  logic       r_open = 1'b1;
  logic [4:0] seek_addr = 5'd0;
  logic       addr_upd = 1'b0;
  logic [3:0] led_out;
  logic       wr_event;

  mem8_regbank #(.ID_VALUE(ID_V), .LED_RESET(LED_R)) dut (
    .bus_clk(bus_clk),
    .bus_rst(bus_rst),
    .user_w_mem_8_wren(wren),
    .user_w_mem_8_data(wdata),
    .user_w_mem_8_full(full),
    .user_w_mem_8_open(w_open),
    .user_r_mem_8_rden(rden),
    .user_r_mem_8_data(rdata),
    .user_r_mem_8_empty(empty),
    .user_r_mem_8_eof(eof),
    .user_r_mem_8_open(r_open),
    .user_mem_8_addr(seek_addr),
    .user_mem_8_addr_update(addr_upd),
    .led_out(led_out),
    .wr_event(wr_event)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  rd;
    logic [3:0]  led;
    logic        wev;
  } exp_t;

  exp_t sb[$];
  int unsigned edge_cnt = 0;
  int n_checks = 0;
  int n_err = 0;
  int wev_seen = 0;

  // Reference model: the 32-byte map as the host sees it.
  logic [7:0] m_ram [0:27];
  logic [3:0] m_led;
  logic [7:0] m_wc, m_rc, m_rd;
  logic [4:0] m_addr;
  logic       m_wev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] map_byte(input logic [4:0] a);
    if (a < 28) return m_ram[a];
    if (a == 28) return {4'h0, m_led};
    if (a == 29) return m_wc;
    if (a == 30) return m_rc;
    return ID_V;
  endfunction

  task automatic cyc(input logic rst, input logic we, input logic [7:0] wd,
                     input logic re, input logic up, input logic [4:0] ua);
    logic [7:0] old;
    exp_t e;
    bus_rst = rst; wren = we; wdata = wd; rden = re; addr_upd = up; seek_addr = ua;
    if (rst) begin
      m_addr = 0; m_wc = 0; m_rc = 0; m_led = LED_R; m_rd = 0; m_wev = 0;
    end else begin
      old = map_byte(m_addr);
      if (re) m_rd = old;
      m_wev = we;
      if (we) begin
        if (m_addr < 28) m_ram[m_addr] = wd;
        else if (m_addr == 28) m_led = wd[3:0];
      end
      if (!w_open && !r_open) begin
        m_wc = 0; m_rc = 0;
      end else begin
        if (we) m_wc = m_wc + 8'd1;
        if (re) m_rc = m_rc + 8'd1;
      end
      if (up) m_addr = ua;
      else if (we || re) m_addr = m_addr + 5'd1;
    end
    e.edge_no = edge_cnt + 1; e.rd = m_rd; e.led = m_led; e.wev = m_wev;
    sb.push_back(e);
    @(posedge bus_clk);
    #1;
  endtask

  task automatic seek(input logic [4:0] a); cyc(0, 0, 8'h00, 0, 1, a); endtask
  task automatic wr(input logic [7:0] d);   cyc(0, 1, d, 0, 0, 5'd0);  endtask
  task automatic rd();                      cyc(0, 0, 8'h00, 1, 0, 5'd0); endtask

  always @(posedge bus_clk) edge_cnt <= edge_cnt + 1;

  exp_t mon_e;
  always @(negedge bus_clk) begin
    while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
      mon_e = sb.pop_front();
      $display("edge %0d: rdata=%0h led=%0h wev=%0b", mon_e.edge_no, rdata, led_out, wr_event);
      chk("rdata", {24'h0, rdata}, {24'h0, mon_e.rd});
      chk("led_out", {28'h0, led_out}, {28'h0, mon_e.led});
      chk("wr_event", {31'h0, wr_event}, {31'h0, mon_e.wev});
    end
    chk("tieoffs", {29'h0, full, empty, eof}, 32'h0);
    if (wr_event) wev_seen++;
  end

  initial begin
    w_open = 1; r_open = 1;
    // Reset with every strobe active.
    cyc(1, 1, 8'hFF, 1, 1, 5'd17);
    cyc(1, 1, 8'hEE, 1, 0, 5'd0);
    rd();                          // address 0 after reset: verify via ID path below
    seek(5'd31);
    rd();                          // ID byte
    // Fill the whole map (including LED and ignored read-only bytes).
    seek(5'd0);
    for (int i = 0; i < 32; i++) wr(8'($urandom));
    // Burst across the LED/counter region.
    seek(5'd26);
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55); wr(8'h66); wr(8'h77);
    chk("led_burst", {28'h0, led_out}, 32'h3);
    seek(5'd26);
    rd(); rd(); rd(); rd();
    // Wrap and rd_cnt readback.
    seek(5'd31);
    rd(); rd();
    seek(5'd30);
    rd();
    // Same-cycle write and read at address 5.
    seek(5'd5);
    wr(8'h10);
    seek(5'd5);
    cyc(0, 1, 8'h99, 1, 0, 5'd0);
    rd();
    seek(5'd5);
    rd();
    // Seek coinciding with a write.
    seek(5'd3);
    cyc(0, 1, 8'h42, 0, 1, 5'd9);
    rd();
    seek(5'd3);
    rd();
    // Counter clear.
    w_open = 0; r_open = 0;
    cyc(0, 0, 8'h00, 0, 0, 5'd0);
    w_open = 1; r_open = 1;
    seek(5'd29);
    rd(); rd();
    // 256 writes wrap wr_cnt back to its start value.
    seek(5'd0);
    wev_seen = 0;
    for (int i = 0; i < 256; i++) wr(8'($urandom));
    @(negedge bus_clk); #1;
    chk("wev_count", wev_seen, 256);
    seek(5'd29);
    rd();
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      w_open = ($urandom_range(0, 19) != 0);
      r_open = ($urandom_range(0, 19) != 0);
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 9) == 0), 5'($urandom));
    end
    w_open = 1; r_open = 1;
    cyc(0, 0, 8'h00, 0, 0, 5'd0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge bus_clk);
    @(negedge bus_clk); #1;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
